// File: rtl/ad_hx711_ctrl.sv
// HX711-class 24-bit load-cell ADC reader: pd_sck/dout framing, gain select, power-down.
// Define AD_AVG_EN to average 2^AVG_LOG2 frames per published value.
module ad_hx711_ctrl #(
  parameter int DATA_W      = 24,
  parameter int SCK_HALF    = 50,
  parameter int TIMEOUT_CYC = 5000000,
  parameter int PDOWN_CYC   = 4000,
  parameter int AVG_LOG2    = 2
) (
  input  logic              clk_50,
  input  logic              rst,
  input  logic              dout,
  output logic              pd_sck,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              pwr_down,
  output logic [DATA_W-1:0] value,
  output logic              value_valid,
  output logic [1:0]        value_mode,
  output logic              sat,
  output logic              busy,
  output logic              timeout_err
);

  localparam int PW = $clog2(DATA_W + 4);

  typedef enum logic [2:0] {
    IDLE, WAIT_RDY, SCK_HI, SCK_LO, GAP, PD_ENTER, PD_HOLD
  } state_t;

  if (SCK_HALF < 4 || AVG_LOG2 < 1) begin : g_bad_param
    $error("ad_hx711_ctrl: SCK_HALF >= 4 and AVG_LOG2 >= 1 required");
  end

  state_t            state;
  logic              dout_m;
  logic              dout_s;
  logic [31:0]       cnt;
  logic [PW-1:0]     pulse_cnt;
  logic [PW-1:0]     pulse_nxt;
  logic [PW-1:0]     pulse_end;
  logic [1:0]        next_mode;
  logic [1:0]        cur_gain;
  logic [1:0]        mode_n;
  logic [DATA_W-1:0] shreg;
  logic              shreg_sat;
  logic              half_end;

  // dout is asynchronous to clk_50
  always_ff @(posedge clk_50) begin
    if (rst) begin
      dout_m <= 1'b1;
      dout_s <= 1'b1;
    end else begin
      dout_m <= dout;
      dout_s <= dout_m;
    end
  end

  assign mode_n    = (mode == 2'd3) ? 2'd0 : mode;
  assign pulse_nxt = pulse_cnt + PW'(1);
  assign pulse_end = PW'(DATA_W + 1) + PW'(next_mode);
  assign half_end  = (cnt == 32'(SCK_HALF - 1));
  assign shreg_sat = (shreg == {1'b0, {(DATA_W-1){1'b1}}}) ||
                     (shreg == {1'b1, {(DATA_W-1){1'b0}}});
  assign busy      = (state == SCK_HI) || (state == SCK_LO) ||
                     (state == GAP);

`ifdef AD_AVG_EN
  localparam int AW = DATA_W + AVG_LOG2;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_sum;
  logic signed [AW-1:0] acc_avg;
  logic [AVG_LOG2-1:0]  frm_cnt;
  logic                 sat_win;

  assign acc_sum = acc + AW'($signed(shreg));
  assign acc_avg = acc_sum >>> AVG_LOG2;
`endif

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state       <= IDLE;
      pd_sck      <= 1'b0;
      value       <= '0;
      value_valid <= 1'b0;
      value_mode  <= '0;
      sat         <= 1'b0;
      timeout_err <= 1'b0;
      cur_gain    <= '0;
      next_mode   <= '0;
      cnt         <= '0;
      pulse_cnt   <= '0;
      shreg       <= '0;
`ifdef AD_AVG_EN
      acc         <= '0;
      frm_cnt     <= '0;
      sat_win     <= 1'b0;
`endif
    end else begin
      value_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en && !pwr_down) begin
            state <= WAIT_RDY;
            cnt   <= '0;
          end
        end
        WAIT_RDY: begin
          if (!dout_s) begin
            next_mode <= mode_n;
            pulse_cnt <= '0;
            cnt       <= '0;
            pd_sck    <= 1'b1;
            state     <= SCK_HI;
          end else if (pwr_down) begin
            cnt    <= '0;
            pd_sck <= 1'b1;
            state  <= PD_ENTER;
          end else if (!en) begin
            state <= IDLE;
          end else if (cnt == 32'(TIMEOUT_CYC - 1)) begin
            timeout_err <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        SCK_HI: begin
          if (half_end) begin
            // sample late in the high phase, after the ADC has shifted
            if (pulse_cnt < PW'(DATA_W))
              shreg <= {shreg[DATA_W-2:0], dout_s};
            pd_sck <= 1'b0;
            cnt    <= '0;
            state  <= SCK_LO;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        SCK_LO: begin
          if (half_end) begin
            cnt       <= '0;
            pulse_cnt <= pulse_nxt;
            if (pulse_nxt == pulse_end) begin
              state <= GAP;
            end else begin
              pd_sck <= 1'b1;
              state  <= SCK_HI;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        GAP: begin
`ifdef AD_AVG_EN
          if (frm_cnt == '1) begin
            value       <= acc_avg[DATA_W-1:0];
            value_valid <= 1'b1;
            value_mode  <= cur_gain;
            sat         <= sat_win | shreg_sat;
            timeout_err <= 1'b0;
            acc         <= '0;
            frm_cnt     <= '0;
            sat_win     <= 1'b0;
          end else if (next_mode != cur_gain) begin
            acc     <= '0;
            frm_cnt <= '0;
            sat_win <= 1'b0;
          end else begin
            acc     <= acc_sum;
            frm_cnt <= frm_cnt + AVG_LOG2'(1);
            sat_win <= sat_win | shreg_sat;
          end
`else
          value       <= shreg;
          value_valid <= 1'b1;
          value_mode  <= cur_gain;
          sat         <= shreg_sat;
          timeout_err <= 1'b0;
`endif
          // pulse count of this frame set the gain of the next one
          cur_gain <= next_mode;
          cnt      <= '0;
          if (pwr_down) begin
            pd_sck <= 1'b1;
            state  <= PD_ENTER;
          end else if (en) begin
            state <= WAIT_RDY;
          end else begin
            state <= IDLE;
          end
        end
        PD_ENTER: begin
          if (cnt == 32'(PDOWN_CYC - 1)) begin
            cnt   <= '0;
            state <= PD_HOLD;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        PD_HOLD: begin
          if (!pwr_down) begin
            pd_sck   <= 1'b0;
            cur_gain <= '0;
            state    <= IDLE;
`ifdef AD_AVG_EN
            acc      <= '0;
            frm_cnt  <= '0;
            sat_win  <= 1'b0;
`endif
          end
        end
        default: begin
          pd_sck <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
